// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, byte type and default FIFO depth
package uart_pkg;
  localparam int UART_DATA_W  = 8;
  localparam int UART_FIFO_AW = 4;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 2**ADDR_W x DATA_W register array, sync write, async read, no reset
//   i_we/i_waddr/i_wdata : write port, captured on clk
//   i_raddr/o_rdata      : combinational read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_AW
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive byte FIFO with occupancy status and sticky overflow
//   wr_en/wr_data : one-cycle push strobe and byte from the receiver
//   rd_en/rd_data : pop request and oldest stored byte (valid while empty=0)
//   empty/full/count : status from registered pointers
//   overflow/ovf_clr : sticky dropped-byte flag and its synchronous clear
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_overflow;
  logic            w_rd;
  logic            w_wr;
  logic            w_ovf_set;
  assign empty = r_wr_ptr == r_rd_ptr;
  assign full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) && (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign overflow = r_overflow;
  assign w_rd = rd_en && !empty;
  // a pop while full frees exactly the slot the write pointer addresses
  assign w_wr = wr_en && (!full || w_rd);
  assign w_ovf_set = wr_en && full && !w_rd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr   <= w_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_overflow <= w_ovf_set || (r_overflow && !ovf_clr);
    end
  uart_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (rd_data)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_rx_fifo dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
  endtask
  task automatic drain;
    rd_en = 1'b1;
    for (int i = 0; i < 40 && !empty; i++) cyc();
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
  endtask
  task automatic test_reset;
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; wr_data = 8'h00;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
  endtask
  task automatic test_basic;
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = exp[i];
      cyc();
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL basic_push_count got %0d exp %0d", count, i + 1); end
      checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL basic_head got %h exp 41", rd_data); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp[i]) begin errors++; $display("FAIL basic_pop_data got %h exp %h", rd_data, exp[i]); end
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      checks++; if (count !== 5'(2 - i)) begin errors++; $display("FAIL basic_pop_count got %0d exp %0d", count, 2 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", empty); end
  endtask
  task automatic test_overflow;
    fill(8'h00);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count16 got %0d exp 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", overflow); end
    wr_en = 1'b1; wr_data = 8'hFF;
    cyc();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold got %0d exp 16", count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovf_pop_data got %h exp %h", rd_data, 8'(i)); end
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b exp 1", empty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask
  task automatic test_full_simul;
    fill(8'h00);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL fs_head got %h exp 00", rd_data); end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fs_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fs_ovf got %b exp 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i == 15) ? 8'hA5 : 8'(i + 1);
      checks++; if (rd_data !== e) begin errors++; $display("FAIL fs_pop_data got %h exp %h", rd_data, e); end
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fs_empty got %b exp 1", empty); end
  endtask
  task automatic test_empty_simul;
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL es_count got %0d exp 1", count); end
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL es_data got %h exp 5a", rd_data); end
    rd_en = 1'b1;
    cyc();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL es_pop_empty got %b exp 1", empty); end
    cyc();
    rd_en = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL es_underflow_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL es_underflow_ovf got %b exp 0", overflow); end
  endtask
  task automatic test_wrap;
    logic [7:0] q [$];
    int next = 0;
    int popped = 0;
    for (int c = 0; c < 300 && popped < 40; c++) begin
      logic w, r;
      w = (next < 40) && ((q.size() < 3) || (q.size() < 7 && (c % 3) != 0));
      r = (q.size() > 0) && ((next >= 40) || (q.size() > 3 && (c % 2) == 0));
      wr_en = w; rd_en = r; wr_data = 8'h80 + 8'(next);
      if (r) begin
        checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL wrap_data got %h exp %h", rd_data, q[0]); end
      end
      cyc();
      if (r) begin void'(q.pop_front()); popped++; end
      if (w) begin q.push_back(8'h80 + 8'(next)); next++; end
      checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL wrap_count got %0d exp %0d", count, q.size()); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (popped != 40) begin errors++; $display("FAIL wrap_done got %0d exp 40", popped); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask
  task automatic test_ovf_clr_race;
    fill(8'h10);
    wr_en = 1'b1; wr_data = 8'hEE;
    cyc();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL race_set got %b exp 1", overflow); end
    ovf_clr = 1'b1;
    cyc();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL race_set_wins got %b exp 1", overflow); end
    cyc();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL race_clear got %b exp 0", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL race_count got %0d exp 16", count); end
    drain();
  endtask
  task automatic test_mid_reset;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL mr_pre_count got %0d exp 5", count); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mr_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mr_full got %b exp 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mr_count got %0d exp 0", count); end
    cyc();
    reset_n = 1'b1;
    cyc();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mr_after_count got %0d exp 0", count); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_ovf_clr_race();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
